// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver blocks:
//   - uart_state_e  : frame sequencer state encoding
//   - UART_CLK_HZ_DEF / UART_BAUD_DEF : default clock and line rate
//   - uart_baud_div : clocks per bit, rounded to nearest, never below 2
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_CLK_HZ_DEF = 50_000_000;
  localparam int unsigned UART_BAUD_DEF   = 115_200;

  // Adding baud/2 before the divide rounds to the nearest integer.
  function automatic int unsigned uart_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    int unsigned div;
    div = (clk_hz + (baud / 2)) / baud;
    return (div < 2) ? 2 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous, active-low reset. The head entry is
// always presented on rdata_o; the consumer captures it on the same edge on
// which it asserts pop_i, and the read pointer advances on that edge.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two).
// The caller must not push when full nor pop when empty.
//
// Ports
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset (empties the FIFO)
//   push_i   in   write wdata_i at the tail
//   wdata_i  in   WIDTH-bit write data
//   pop_i    in   discard the head entry
//   rdata_o  out  head entry
//   count_o  out  number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// CPU-writable UART transmitter: a FIFO of bytes feeding a frame sequencer
// that serialises start, 8 data bits (LSB first), optional even parity and
// one stop bit. Every line bit lasts DIV = round(CLK_HZ/BAUD) clocks.
//
// Build option
//   UART_TX_PARITY_EN  defined  : 8E1, 11-bit frame (PARITY state used)
//                      undefined: 8N1, 10-bit frame, no parity logic
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous active-low reset
//   addr   in   register select: 0 = data (push), 1 = control
//   din    in   8-bit write data
//   we     in   write strobe (qualified by cs)
//   cs     in   chip select
//   dout   out  status {5'b0, ovf, full, idle}, independent of addr
//   tx     out  serial line, registered, idle high
//   busy   out  FIFO non-empty or frame in progress
//
// Sequencer states
//   state   | meaning
//   IDLE    | line high, waiting for a queued byte
//   START   | start bit (low)
//   DATA    | 8 data bits, LSB first
//   PARITY  | even parity of the data byte (parity build only)
//   STOP    | stop bit (high); chains straight to START if bytes remain
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = UART_CLK_HZ_DEF,
  parameter int unsigned BAUD       = UART_BAUD_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       we,
  input  logic       cs,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DIV = uart_baud_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LOAD  = CW'(DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

  // -------------------------------------------------------------------------
  // Register interface and FIFO
  // -------------------------------------------------------------------------
  logic        wr_data, wr_ctrl;
  logic        fifo_push, fifo_pop;
  logic [7:0]  fifo_rdata;
  logic [AW:0] fifo_count;
  logic        fifo_full, fifo_empty;
  logic        ovf_q;

  assign wr_data = cs & we & ~addr;
  assign wr_ctrl = cs & we & addr;

  // Full is the registered count, so a write that lands on the same edge as
  // a pop from a full FIFO is still dropped.
  assign fifo_full  = (fifo_count == FIFO_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_push  = reset & wr_data & ~fifo_full;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .wdata_i (din),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (wr_data && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (wr_ctrl && din[0]) begin
      ovf_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Frame sequencer
  // -------------------------------------------------------------------------
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    data_d   = data_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          cnt_d    = CNT_LOAD;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = ST_AFTER_DATA;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif

      ST_STOP: begin
        if (cnt_q == '0) begin
          // Back-to-back frames: pop here so the next start bit follows the
          // stop bit with no idle clock in between.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rdata;
            cnt_d    = CNT_LOAD;
            state_d  = ST_START;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // The line level is a registered decode of the current state, so tx lags
  // the state by one clock; every state lasts DIV clocks, so each line bit
  // does too.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^data_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic idle;

  assign idle = (state_q == ST_IDLE) && fifo_empty;
  assign busy = ~idle;
  assign tx   = tx_q;
  assign dout = {5'b0, ovf_q, fifo_full, idle};

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Drives uart_tx with directed and random register writes. A reference model
// keeps the queued bytes in a queue and predicts the line from frame timing
// arithmetic: a byte leaves the queue when the line is free, and its frame is
// NB bits of DIV clocks each, starting one clock after that pop.
// tx, dout and busy are compared every clock on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 3_000_000;
  localparam int unsigned DEPTH  = 8;

  // 50e6 / 3e6 = 16.67, nearest integer is 17.
  localparam int DIV_RAW = int'((2 * longint'(CLK_HZ) / longint'(BAUD) + 1) / 2);
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       reset, addr, we, cs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       tx, busy;

  always #10 clk = ~clk;

  uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .we    (we),
    .cs    (cs),
    .tx    (tx),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model
  logic [7:0] m_q[$];
  logic       m_ovf  = 1'b0;
  int         m_free = 0;
  int         m_p    = -1000000;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic frame_bit(input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 8) return m_data[idx-1];
    if (NB == 11 && idx == 9) begin
      ones = 0;
      for (int j = 0; j < 8; j++) ones += int'(m_data[j]);
      return logic'(ones % 2);
    end
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    int k;
    k = cyc - m_p - 1;
    if (k >= 0 && k < FRAME) return frame_bit(k / DIV);
    return 1'b1;
  endfunction

  task automatic tick(input logic r, input logic c, input logic w,
                      input logic a, input logic [7:0] d);
    logic full_pre, do_pop, exp_busy;
    reset = r; cs = c; we = w; addr = a; din = d;
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_free = cyc;
      m_p    = -1000000;
    end else begin
      full_pre = (m_q.size() == DEPTH);
      do_pop   = (cyc >= m_free) && (m_q.size() > 0);
      if (do_pop) begin
        m_data = m_q.pop_front();
        m_p    = cyc;
        m_free = cyc + FRAME;
      end
      if (c && w && !a) begin
        if (full_pre) m_ovf = 1'b1;
        else          m_q.push_back(d);
      end
      if (c && w && a && d[0]) m_ovf = 1'b0;
    end
    @(negedge clk);
    exp_busy = (m_q.size() > 0) || (cyc < m_free);
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("dout", 32'(dout), 32'({5'b0, m_ovf, (m_q.size() == DEPTH), ~exp_busy}));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr_data(input logic [7:0] d);
    tick(1'b1, 1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    tick(1'b1, 1'b1, 1'b1, 1'b1, d);
  endtask

  initial begin
    int sel;
    logic r;

    // Reset, with a write attempt that must be ignored
    tick(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset_dout", 32'(dout), 32'h01);
    chk("reset_tx", 32'(tx), 32'h1);
    idle_cycles(5);

    // Single byte
    wr_data(8'h55);
    idle_cycles(FRAME + 20);
    chk("single_done_busy", 32'(busy), 32'h0);

    // Back-to-back, then parity-distinguishing bytes
    wr_data(8'hA0);
    wr_data(8'h0F);
    idle_cycles(2 * FRAME + 20);
    wr_data(8'h07);
    wr_data(8'h03);
    idle_cycles(2 * FRAME + 20);

    // Nine consecutive writes: all accepted
    for (int i = 0; i < 9; i++) wr_data(8'($urandom));
    chk("ovf9", 32'(dout[2]), 32'h0);
    idle_cycles(9 * FRAME + 20);

    // Ten consecutive writes: the tenth is dropped
    for (int i = 0; i < 10; i++) wr_data(8'($urandom));
    chk("ovf10", 32'(dout[2]), 32'h1);
    idle_cycles(9 * FRAME + 20);
    chk("ovf10_held", 32'(dout[2]), 32'h1);
    wr_ctrl(8'h01);
    chk("ovf_cleared", 32'(dout[2]), 32'h0);

    // Fill the FIFO, then write on the edge where the stop bit ends and pops
    for (int i = 0; i < 9; i++) wr_data(8'($urandom));
    chk("fill_full", 32'(dout[1]), 32'h1);
    for (int g = 0; g < 2 * FRAME && (cyc + 1) != m_free; g++) idle_cycles(1);
    wr_data(8'hC3);
    chk("coincide_ovf", 32'(dout[2]), 32'h1);
    chk("coincide_full", 32'(dout[1]), 32'h0);
    idle_cycles(8 * FRAME + 20);
    wr_ctrl(8'hFF);

    // Reset in mid-frame with bytes queued
    for (int i = 0; i < 4; i++) wr_data(8'($urandom));
    idle_cycles(FRAME / 2);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    chk("midrst_dout", 32'(dout), 32'h01);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_tx", 32'(tx), 32'h1);
    idle_cycles(2 * FRAME);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      r   = ($urandom_range(0, 1999) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 4)       tick(r, 1'b1, 1'b1, 1'b0, 8'($urandom));
      else if (sel == 4) tick(r, 1'b1, 1'b1, 1'b1, 8'($urandom));
      else if (sel == 5) tick(r, 1'b1, 1'b0, 1'($urandom), 8'($urandom));
      else               tick(r, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    idle_cycles(9 * FRAME + 20);
    chk("final_idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
